// File: rtl/victim_cache_ctrl_pkg.sv
// Shared sizing, block/request payload types and FSM encoding for the victim cache controller.
package cache_def;
    localparam int unsigned WAYS_VC      = 4;
    localparam int unsigned INDEX_WAY_VC = 2;
    localparam int unsigned TAG_VC       = 28;
    localparam int unsigned BLOCK_W      = 128;

    typedef logic [BLOCK_W-1:0] cache_data_type;

    typedef struct packed {
        logic [TAG_VC-1:0] tag;
        logic              dirty;
        cache_data_type    data;
    } vc_req_t;

    typedef enum logic [2:0] {
        IDLE,
        P_LOOKUP,
        P_RESP,
        I_CHECK,
        I_WB,
        I_WRITE
    } vc_state_e;
endpackage

// File: rtl/victim_cache_ctrl_tag_array.sv
// Per-way valid/dirty/tag storage with lowest-index tag match and lowest free-way search.
module vc_tag_array
    import cache_def::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [TAG_VC-1:0]       cmp_tag_i,
    input  logic [INDEX_WAY_VC-1:0] rd_way_i,
    input  logic                    wr_en_i,
    input  logic [INDEX_WAY_VC-1:0] wr_way_i,
    input  logic [TAG_VC-1:0]       wr_tag_i,
    input  logic                    wr_dirty_i,
    input  logic                    clr_en_i,
    input  logic [INDEX_WAY_VC-1:0] clr_way_i,
    output logic                    hit_c,
    output logic [INDEX_WAY_VC-1:0] hit_way_c,
    output logic                    hit_dirty_c,
    output logic                    free_c,
    output logic [INDEX_WAY_VC-1:0] free_way_c,
    output logic                    rd_valid_c,
    output logic                    rd_dirty_c,
    output logic [TAG_VC-1:0]       rd_tag_c
);
    logic [WAYS_VC-1:0] valid_q, valid_d;
    logic [WAYS_VC-1:0] dirty_q, dirty_d;
    logic [TAG_VC-1:0]  tag_q [WAYS_VC];
    logic [TAG_VC-1:0]  tag_d [WAYS_VC];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int unsigned i = 0; i < WAYS_VC; i++) tag_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
        end
    end

    // A fill in the same cycle as a clear targets a different way; write wins if they ever coincide.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        if (clr_en_i) begin
            valid_d[clr_way_i] = 1'b0;
            dirty_d[clr_way_i] = 1'b0;
        end
        if (wr_en_i) begin
            valid_d[wr_way_i] = 1'b1;
            dirty_d[wr_way_i] = wr_dirty_i;
            tag_d[wr_way_i]   = wr_tag_i;
        end
    end

    // Scan high-to-low so the lowest matching / free way is the one left standing.
    always_comb begin
        hit_c      = 1'b0;
        hit_way_c  = '0;
        free_c     = 1'b0;
        free_way_c = '0;
        for (int i = int'(WAYS_VC) - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == cmp_tag_i)) begin
                hit_c     = 1'b1;
                hit_way_c = INDEX_WAY_VC'(i);
            end
            if (!valid_q[i]) begin
                free_c     = 1'b1;
                free_way_c = INDEX_WAY_VC'(i);
            end
        end
    end

    assign hit_dirty_c = dirty_q[hit_way_c];
    assign rd_valid_c  = valid_q[rd_way_i];
    assign rd_dirty_c  = dirty_q[rd_way_i];
    assign rd_tag_c    = tag_q[rd_way_i];
endmodule

// File: rtl/victim_cache_ctrl.sv
// Victim cache controller: probe (swap-out on hit) and insert (with dirty writeback) sequencing.
module victim_cache_ctrl
    import cache_def::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    probe_valid_i,
    input  logic [TAG_VC-1:0]       probe_tag_i,
    output logic                    probe_ready_o,
    output logic                    probe_done_o,
    output logic                    probe_hit_o,
    output logic                    probe_dirty_o,
    output cache_data_type          probe_data_o,
    input  logic                    ins_valid_i,
    input  logic [TAG_VC-1:0]       ins_tag_i,
    input  cache_data_type          ins_data_i,
    input  logic                    ins_dirty_i,
    output logic                    ins_ready_o,
    output logic                    wb_valid_o,
    output logic [TAG_VC-1:0]       wb_tag_o,
    output cache_data_type          wb_data_o,
    input  logic                    wb_ready_i,
    output logic                    data_we_o,
    output logic [INDEX_WAY_VC-1:0] data_way_o,
    output cache_data_type          data_write_o,
    input  cache_data_type          data_read_i
);
    vc_state_e               state_q, state_d;
    vc_req_t                 req_q, req_d;
    logic [INDEX_WAY_VC-1:0] way_q, way_d;
    logic [INDEX_WAY_VC-1:0] ptr_q, ptr_d;
    logic                    hit_q, hit_d;
    logic                    hdirty_q, hdirty_d;
    logic                    from_ptr_q, from_ptr_d;

    logic [INDEX_WAY_VC-1:0] victim_c, rd_way_c;
    logic                    victim_from_ptr_c;
    logic                    wr_en_c, clr_en_c;
    logic                    ta_hit_c, ta_free_c, ta_hit_dirty_c;
    logic [INDEX_WAY_VC-1:0] ta_hit_way_c, ta_free_way_c;
    logic                    ta_rd_valid_c, ta_rd_dirty_c;
    logic [TAG_VC-1:0]       ta_rd_tag_c;

    vc_tag_array u_tag_array (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmp_tag_i   (req_q.tag),
        .rd_way_i    (rd_way_c),
        .wr_en_i     (wr_en_c),
        .wr_way_i    (way_q),
        .wr_tag_i    (req_q.tag),
        .wr_dirty_i  (req_q.dirty),
        .clr_en_i    (clr_en_c),
        .clr_way_i   (way_q),
        .hit_c       (ta_hit_c),
        .hit_way_c   (ta_hit_way_c),
        .hit_dirty_c (ta_hit_dirty_c),
        .free_c      (ta_free_c),
        .free_way_c  (ta_free_way_c),
        .rd_valid_c  (ta_rd_valid_c),
        .rd_dirty_c  (ta_rd_dirty_c),
        .rd_tag_c    (ta_rd_tag_c)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            req_q      <= '0;
            way_q      <= '0;
            ptr_q      <= '0;
            hit_q      <= 1'b0;
            hdirty_q   <= 1'b0;
            from_ptr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            way_q      <= way_d;
            ptr_q      <= ptr_d;
            hit_q      <= hit_d;
            hdirty_q   <= hdirty_d;
            from_ptr_q <= from_ptr_d;
        end
    end

    // Victim priority: same-tag overwrite, then lowest free way, then FIFO pointer.
    always_comb begin
        victim_c          = ptr_q;
        victim_from_ptr_c = 1'b1;
        if (ta_hit_c) begin
            victim_c          = ta_hit_way_c;
            victim_from_ptr_c = 1'b0;
        end else if (ta_free_c) begin
            victim_c          = ta_free_way_c;
            victim_from_ptr_c = 1'b0;
        end
    end

    assign rd_way_c = (state_q == I_CHECK) ? victim_c : way_q;

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        way_d         = way_q;
        ptr_d         = ptr_q;
        hit_d         = hit_q;
        hdirty_d      = hdirty_q;
        from_ptr_d    = from_ptr_q;
        wr_en_c       = 1'b0;
        clr_en_c      = 1'b0;
        probe_ready_o = 1'b0;
        ins_ready_o   = 1'b0;
        probe_done_o  = 1'b0;
        probe_hit_o   = 1'b0;
        probe_dirty_o = 1'b0;
        probe_data_o  = '0;
        wb_valid_o    = 1'b0;
        wb_tag_o      = '0;
        wb_data_o     = '0;
        data_we_o     = 1'b0;
        data_way_o    = way_q;
        data_write_o  = '0;

        unique case (state_q)
            IDLE: begin
                probe_ready_o = 1'b1;
                ins_ready_o   = !probe_valid_i;
                if (probe_valid_i) begin
                    req_d.tag = probe_tag_i;
                    state_d   = P_LOOKUP;
                end else if (ins_valid_i) begin
                    req_d.tag   = ins_tag_i;
                    req_d.data  = ins_data_i;
                    req_d.dirty = ins_dirty_i;
                    state_d     = I_CHECK;
                end
            end
            P_LOOKUP: begin
                data_way_o = ta_hit_way_c;
                way_d      = ta_hit_way_c;
                hit_d      = ta_hit_c;
                hdirty_d   = ta_hit_dirty_c;
                state_d    = P_RESP;
            end
            P_RESP: begin
                probe_done_o  = 1'b1;
                probe_hit_o   = hit_q;
                probe_dirty_o = hit_q & hdirty_q;
                probe_data_o  = hit_q ? data_read_i : '0;
                clr_en_c      = hit_q;
                state_d       = IDLE;
            end
            I_CHECK: begin
                data_way_o = victim_c;
                way_d      = victim_c;
                from_ptr_d = victim_from_ptr_c;
                if (ta_rd_valid_c && ta_rd_dirty_c && (ta_rd_tag_c != req_q.tag)) begin
                    state_d = I_WB;
                end else begin
                    state_d = I_WRITE;
                end
            end
            I_WB: begin
                wb_valid_o = 1'b1;
                wb_tag_o   = ta_rd_tag_c;
                wb_data_o  = data_read_i;
                if (wb_ready_i) state_d = I_WRITE;
            end
            I_WRITE: begin
                data_we_o    = 1'b1;
                data_write_o = req_q.data;
                wr_en_c      = 1'b1;
                if (from_ptr_q) begin
                    ptr_d = (ptr_q == INDEX_WAY_VC'(WAYS_VC - 1)) ? '0 : ptr_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Randomized self-checking bench for victim_cache_ctrl against an array-based cache model.
module tb_victim_cache_ctrl;
    import cache_def::*;

    logic                    clk = 1'b0;
    logic                    rst_i = 1'b1;
    logic                    probe_valid_i = 1'b0;
    logic [TAG_VC-1:0]       probe_tag_i = '0;
    logic                    probe_ready_o, probe_done_o, probe_hit_o, probe_dirty_o;
    cache_data_type          probe_data_o;
    logic                    ins_valid_i = 1'b0;
    logic [TAG_VC-1:0]       ins_tag_i = '0;
    cache_data_type          ins_data_i = '0;
    logic                    ins_dirty_i = 1'b0;
    logic                    ins_ready_o;
    logic                    wb_valid_o;
    logic [TAG_VC-1:0]       wb_tag_o;
    cache_data_type          wb_data_o;
    logic                    wb_ready_i = 1'b0;
    logic                    data_we_o;
    logic [INDEX_WAY_VC-1:0] data_way_o;
    cache_data_type          data_write_o;
    cache_data_type          data_read_i;

    int n_checks = 0;
    int n_fail   = 0;
    int we_count = 0;

    always #5 clk = ~clk;

    victim_cache_ctrl dut (
        .clk_i(clk), .rst_i(rst_i),
        .probe_valid_i(probe_valid_i), .probe_tag_i(probe_tag_i), .probe_ready_o(probe_ready_o),
        .probe_done_o(probe_done_o), .probe_hit_o(probe_hit_o), .probe_dirty_o(probe_dirty_o),
        .probe_data_o(probe_data_o),
        .ins_valid_i(ins_valid_i), .ins_tag_i(ins_tag_i), .ins_data_i(ins_data_i),
        .ins_dirty_i(ins_dirty_i), .ins_ready_o(ins_ready_o),
        .wb_valid_o(wb_valid_o), .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o), .wb_ready_i(wb_ready_i),
        .data_we_o(data_we_o), .data_way_o(data_way_o), .data_write_o(data_write_o),
        .data_read_i(data_read_i)
    );

    // External data array: combinational read, clocked write.
    cache_data_type dmem [WAYS_VC];
    assign data_read_i = dmem[data_way_o];
    always @(posedge clk) begin
        if (data_we_o) begin
            dmem[data_way_o] <= data_write_o;
            we_count <= we_count + 1;
        end
    end

    // Reference model: what the cache should hold, derived from the replacement rules.
    logic           m_valid [WAYS_VC];
    logic           m_dirty [WAYS_VC];
    logic [27:0]    m_tag   [WAYS_VC];
    cache_data_type m_data  [WAYS_VC];
    int             m_ptr;

    task automatic m_clear();
        for (int i = 0; i < int'(WAYS_VC); i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
        end
        m_ptr = 0;
    endtask

    task automatic m_insert(input logic [27:0] t, input cache_data_type d, input logic dty,
                            output int way, output bit wb, output logic [27:0] wbtag,
                            output cache_data_type wbdata);
        way = -1;
        for (int i = 0; i < int'(WAYS_VC); i++)
            if (way < 0 && m_valid[i] && m_tag[i] == t) way = i;
        for (int i = 0; i < int'(WAYS_VC); i++)
            if (way < 0 && !m_valid[i]) way = i;
        if (way < 0) begin
            way   = m_ptr;
            m_ptr = (m_ptr + 1) % int'(WAYS_VC);
        end
        wb     = m_valid[way] && m_dirty[way] && (m_tag[way] != t);
        wbtag  = m_tag[way];
        wbdata = m_data[way];
        m_valid[way] = 1'b1; m_dirty[way] = dty; m_tag[way] = t; m_data[way] = d;
    endtask

    task automatic m_probe(input logic [27:0] t, output bit hit, output bit dty,
                           output cache_data_type d);
        hit = 0; dty = 0; d = '0;
        for (int i = 0; i < int'(WAYS_VC); i++) begin
            if (!hit && m_valid[i] && m_tag[i] == t) begin
                hit = 1; dty = m_dirty[i]; d = m_data[i]; m_valid[i] = 1'b0;
            end
        end
    endtask

    function automatic cache_data_type rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic apply_reset();
        rst_i = 1'b1;
        probe_valid_i = 1'b0; ins_valid_i = 1'b0; wb_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        m_clear();
    endtask

    // Drivers return what they observed; lat is cycles from the accept edge, -1 on timeout.
    task automatic do_probe(input logic [27:0] t, output int lat, output logic hit,
                            output logic dty, output cache_data_type d);
        int n = 0;
        probe_valid_i = 1'b1; probe_tag_i = t;
        while (!probe_ready_o && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        probe_valid_i = 1'b0;
        lat = 1;
        while (!probe_done_o && lat < 20) begin @(posedge clk); #1; lat++; end
        hit = probe_hit_o; dty = probe_dirty_o; d = probe_data_o;
        if (!probe_done_o) lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic do_insert(input logic [27:0] t, input cache_data_type d, input logic dty,
                             input int stall, output int lat, output int wbc,
                             output logic [27:0] wtag, output cache_data_type wdata,
                             output logic wstable, output int way, output cache_data_type wr);
        int n = 0;
        bit done = 0;
        wbc = 0; wtag = '0; wdata = '0; wstable = 1'b1; way = -1; wr = '0;
        ins_valid_i = 1'b1; ins_tag_i = t; ins_data_i = d; ins_dirty_i = dty; wb_ready_i = 1'b0;
        while (!ins_ready_o && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        ins_valid_i = 1'b0;
        lat = 1;
        while (!done && lat < 60) begin
            if (data_we_o) begin
                way = int'(data_way_o); wr = data_write_o; done = 1;
            end else begin
                if (wb_valid_o) begin
                    wbc++;
                    if (wbc == 1) begin wtag = wb_tag_o; wdata = wb_data_o; end
                    else if (wb_tag_o !== wtag || wb_data_o !== wdata) wstable = 1'b0;
                    wb_ready_i = (wbc > stall);
                end
                @(posedge clk); #1;
                lat++;
            end
        end
        if (!done) lat = -1;
        wb_ready_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (probe_ready_o !== 1'b1 || ins_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: probe_ready=%b ins_ready=%b, need 1 1", probe_ready_o, ins_ready_o);
        end
        n_checks++;
        if ({probe_done_o, probe_hit_o, probe_dirty_o, wb_valid_o, data_we_o} !== 5'b0 ||
            probe_data_o !== '0 || wb_tag_o !== '0 || wb_data_o !== '0 ||
            data_way_o !== '0 || data_write_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: done=%b hit=%b wbv=%b we=%b way=%0d, need all zero",
                     probe_done_o, probe_hit_o, wb_valid_o, data_we_o, data_way_o);
        end
    endtask

    task automatic test_fill();
        int lat, wbc, way, ew; logic [27:0] wt, ewt; cache_data_type wd, wr, d, ewd;
        logic ws; bit ewb;
        for (int i = 0; i < 4; i++) begin
            d = rand_block();
            m_insert(28'h10 + 28'(i), d, 1'b0, ew, ewb, ewt, ewd);
            do_insert(28'h10 + 28'(i), d, 1'b0, 0, lat, wbc, wt, wd, ws, way, wr);
            n_checks++;
            if (way != ew || way != i || wr !== d || wbc != 0 || lat != 2) begin
                n_fail++;
                $display("FAIL fill[%0d]: way=%0d wb_cycles=%0d lat=%0d data_ok=%0b, need way=%0d wb_cycles=0 lat=2",
                         i, way, wbc, lat, wr === d, ew);
            end
        end
    endtask

    task automatic test_probe_hit();
        int lat; logic h, dt; cache_data_type d, ed; bit eh, edt;
        for (int k = 0; k < 2; k++) begin
            m_probe(28'h12, eh, edt, ed);
            do_probe(28'h12, lat, h, dt, d);
            n_checks++;
            if (h !== eh || dt !== edt || d !== ed || lat != 2) begin
                n_fail++;
                $display("FAIL probe_0x12[%0d]: hit=%b dirty=%b lat=%0d data_ok=%0b, need hit=%0b dirty=%0b lat=2",
                         k, h, dt, lat, d === ed, eh, edt);
            end
        end
    endtask

    // Refill way 2, dirty way 0 via same-tag overwrite, then evict it with a stalled writeback.
    task automatic test_dirty_evict();
        int lat, wbc, way, ew; logic [27:0] wt, ewt; cache_data_type wd, wr, d, ewd;
        logic ws; bit ewb;
        logic [27:0] tags [3] = '{28'h12, 28'h10, 28'h20};
        logic        dts  [3] = '{1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            d = rand_block();
            m_insert(tags[k], d, dts[k], ew, ewb, ewt, ewd);
            do_insert(tags[k], d, dts[k], 5, lat, wbc, wt, wd, ws, way, wr);
            n_checks++;
            if (way != ew || wr !== d || wbc != (ewb ? 6 : 0) || lat != (ewb ? 8 : 2)) begin
                n_fail++;
                $display("FAIL evict_step[%0d]: way=%0d wb_cycles=%0d lat=%0d, need way=%0d wb_cycles=%0d lat=%0d",
                         k, way, wbc, lat, ew, ewb ? 6 : 0, ewb ? 8 : 2);
            end
        end
        n_checks++;
        if (wt !== 28'h10 || wd !== ewd || ws !== 1'b1 || way != 0) begin
            n_fail++;
            $display("FAIL evict_wb: wb_tag=%h stable=%b data_ok=%0b way=%0d, need tag=10 stable=1 way=0",
                     wt, ws, wd === ewd, way);
        end
    endtask

    task automatic test_duplicate_collision();
        int lat, wbc, way, ew; logic [27:0] wt, ewt; cache_data_type wd, wr, d, ewd, ed;
        logic ws; bit ewb, eh, edt;
        d = rand_block();
        m_insert(28'h11, d, 1'b0, ew, ewb, ewt, ewd);
        do_insert(28'h11, d, 1'b0, 0, lat, wbc, wt, wd, ws, way, wr);
        n_checks++;
        if (way != 1 || way != ew || wbc != 0 || wr !== d || dmem[1] !== d) begin
            n_fail++;
            $display("FAIL dup_0x11: way=%0d wb_cycles=%0d, need way=1 wb_cycles=0", way, wbc);
        end
        m_probe(28'h13, eh, edt, ed);
        probe_valid_i = 1'b1; probe_tag_i = 28'h13;
        ins_valid_i = 1'b1; ins_tag_i = 28'h77; ins_data_i = rand_block(); ins_dirty_i = 1'b1;
        #1;
        n_checks++;
        if (probe_ready_o !== 1'b1 || ins_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_ready: probe_ready=%b ins_ready=%b, need 1 0", probe_ready_o, ins_ready_o);
        end
        @(posedge clk); #1;
        probe_valid_i = 1'b0; ins_valid_i = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (probe_done_o !== 1'b1 || probe_hit_o !== eh || probe_data_o !== ed || data_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_probe: done=%b hit=%b we=%b, need done=1 hit=%0b we=0",
                     probe_done_o, probe_hit_o, data_we_o, eh);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        int lat, wbc, way, ew; logic [27:0] wt, ewt; cache_data_type wd, wr, d, ewd;
        logic ws; bit ewb;
        int exp_way [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            d = rand_block();
            m_insert(28'h30 + 28'(i), d, 1'b0, ew, ewb, ewt, ewd);
            do_insert(28'h30 + 28'(i), d, 1'b0, 0, lat, wbc, wt, wd, ws, way, wr);
            n_checks++;
            if (way != ew || (i >= 4 && way != exp_way[i-4]) || wbc != 0 || lat != 2) begin
                n_fail++;
                $display("FAIL wrap[%0d]: way=%0d wb_cycles=%0d lat=%0d, need way=%0d",
                         i, way, wbc, lat, ew);
            end
        end
    endtask

    task automatic test_random();
        int lat, wbc, way, ew, st; logic [27:0] wt, ewt, t; cache_data_type wd, wr, d, ewd, ed;
        logic ws, h, dt, dty; bit ewb, eh, edt;
        for (int k = 0; k < 40; k++) begin
            t = 28'h40 + 28'($urandom_range(0, 5));
            if ($urandom_range(0, 2) == 0) begin
                m_probe(t, eh, edt, ed);
                do_probe(t, lat, h, dt, d);
                n_checks++;
                if (h !== eh || dt !== edt || d !== ed || lat != 2) begin
                    n_fail++;
                    $display("FAIL rand_probe[%0d] tag=%h: hit=%b dirty=%b lat=%0d, need hit=%0b dirty=%0b lat=2",
                             k, t, h, dt, lat, eh, edt);
                end
            end else begin
                d = rand_block(); dty = 1'($urandom_range(0, 1)); st = $urandom_range(0, 3);
                m_insert(t, d, dty, ew, ewb, ewt, ewd);
                do_insert(t, d, dty, st, lat, wbc, wt, wd, ws, way, wr);
                n_checks++;
                if (way != ew || wr !== d || wbc != (ewb ? st + 1 : 0) ||
                    lat != (ewb ? st + 3 : 2) || (ewb && (wt !== ewt || wd !== ewd || ws !== 1'b1))) begin
                    n_fail++;
                    $display("FAIL rand_insert[%0d] tag=%h: way=%0d wb_cycles=%0d lat=%0d wb_tag=%h, need way=%0d wb=%0b wb_tag=%h",
                             k, t, way, wbc, lat, wt, ew, ewb, ewt);
                end
            end
        end
    endtask

    task automatic test_reset_mid_wb();
        int lat, wbc, way, ew, we_before, n; logic [27:0] wt, ewt; cache_data_type wd, wr, d, ewd;
        logic ws, h, dt; bit ewb;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            d = rand_block();
            m_insert(28'h50 + 28'(i), d, 1'b1, ew, ewb, ewt, ewd);
            do_insert(28'h50 + 28'(i), d, 1'b1, 0, lat, wbc, wt, wd, ws, way, wr);
        end
        ins_valid_i = 1'b1; ins_tag_i = 28'h60; ins_data_i = rand_block(); ins_dirty_i = 1'b0;
        wb_ready_i = 1'b0;
        @(posedge clk); #1;
        ins_valid_i = 1'b0;
        n = 0;
        while (!wb_valid_o && n < 10) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (wb_valid_o !== 1'b1 || wb_tag_o !== 28'h50) begin
            n_fail++;
            $display("FAIL rst_wb_entry: wb_valid=%b wb_tag=%h, need 1 50", wb_valid_o, wb_tag_o);
        end
        @(posedge clk); #1;
        we_before = we_count;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        m_clear();
        n_checks++;
        if (wb_valid_o !== 1'b0 || data_we_o !== 1'b0 || probe_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wb_drop: wb_valid=%b we=%b probe_ready=%b, need 0 0 1",
                     wb_valid_o, data_we_o, probe_ready_o);
        end
        for (int i = 0; i < 5; i++) begin
            do_probe(i < 4 ? 28'h50 + 28'(i) : 28'h60, lat, h, dt, d);
            n_checks++;
            if (h !== 1'b0 || d !== '0 || lat != 2) begin
                n_fail++;
                $display("FAIL rst_probe[%0d]: hit=%b lat=%0d, need hit=0 lat=2", i, h, lat);
            end
        end
        n_checks++;
        if (we_count != we_before) begin
            n_fail++;
            $display("FAIL rst_no_write: data writes=%0d, need %0d", we_count, we_before);
        end
    endtask

    initial begin
        m_clear();
        test_reset();
        test_fill();
        test_probe_hit();
        test_dirty_evict();
        test_duplicate_collision();
        test_wrap();
        test_random();
        test_reset_mid_wb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
